// File: rtl/hack_encoder_if.sv
// Record-in / ROM-write-out handshake bundle for the Hack encoder.
interface hack_encoder_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_c;
  logic [14:0]       in_value;
  logic [4:0]        in_comp;
  logic [2:0]        in_dest;
  logic [2:0]        in_jump;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [15:0]       out_instr;

  // Encoder side: consumes records, produces ROM writes.
  modport master (
    input  in_valid, in_is_c, in_value, in_comp, in_dest, in_jump, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );

  // Environment side: produces records, consumes ROM writes.
  modport slave (
    output in_valid, in_is_c, in_value, in_comp, in_dest, in_jump, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/hack_encoder.sv
// Hack assembler back end: encodes A/C field records into 16-bit instructions
// and emits them as sequential ROM writes through a single output register.
module hack_encoder #(
  parameter int unsigned DEPTH  = 32768,
  parameter int unsigned ADDR_W = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  hack_encoder_if.master  bus,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            err_comp
);

  localparam logic [ADDR_W:0] DepthC   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CountOne = (ADDR_W + 1)'(1);

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [15:0]       out_instr_q, out_instr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic accept, comp_bad, emit, taken;
  logic [6:0]  acomp;
  logic [15:0] enc;

  // Mnemonic index -> {a, c1..c6}; 18..27 are the M forms of the A mnemonics.
  function automatic logic [6:0] comp_bits(input logic [4:0] idx);
    logic [6:0] r;
    case (idx)
      5'd0:    r = 7'b0101010;
      5'd1:    r = 7'b0111111;
      5'd2:    r = 7'b0111010;
      5'd3:    r = 7'b0001100;
      5'd4:    r = 7'b0110000;
      5'd5:    r = 7'b0001101;
      5'd6:    r = 7'b0110001;
      5'd7:    r = 7'b0001111;
      5'd8:    r = 7'b0110011;
      5'd9:    r = 7'b0011111;
      5'd10:   r = 7'b0110111;
      5'd11:   r = 7'b0001110;
      5'd12:   r = 7'b0110010;
      5'd13:   r = 7'b0000010;
      5'd14:   r = 7'b0010011;
      5'd15:   r = 7'b0000111;
      5'd16:   r = 7'b0000000;
      5'd17:   r = 7'b0010101;
      5'd18:   r = 7'b1110000;
      5'd19:   r = 7'b1110001;
      5'd20:   r = 7'b1110011;
      5'd21:   r = 7'b1110111;
      5'd22:   r = 7'b1110010;
      5'd23:   r = 7'b1000010;
      5'd24:   r = 7'b1010011;
      5'd25:   r = 7'b1000111;
      5'd26:   r = 7'b1000000;
      5'd27:   r = 7'b1010101;
      default: r = 7'b0000000;
    endcase
    return r;
  endfunction

  // Handshake decode and instruction encoding.
  always_comb begin
    bus.in_ready = !reset && !full_q && (!out_valid_q || bus.out_ready);
    accept       = bus.in_valid && bus.in_ready;
    comp_bad     = bus.in_is_c && (bus.in_comp >= 5'd28);
    emit         = accept && !comp_bad;
    taken        = out_valid_q && bus.out_ready;
    acomp        = comp_bits(bus.in_comp);
    enc          = bus.in_is_c ? {3'b111, acomp, bus.in_dest, bus.in_jump}
                               : {1'b0, bus.in_value};
  end

  // Next state: clear wins, otherwise load on emit or drain on a taken write.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    if (clear) begin
      out_valid_d = 1'b0;
      count_d     = '0;
      full_d      = 1'b0;
      err_d       = 1'b0;
    end else begin
      if (emit) begin
        out_valid_d = 1'b1;
        out_addr_d  = count_q[ADDR_W-1:0];
        out_instr_d = enc;
        count_d     = count_q + CountOne;
        full_d      = (count_q + CountOne) == DepthC;
      end else if (taken) begin
        out_valid_d = 1'b0;
      end
      if (accept && comp_bad) begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_instr = out_instr_q;
  assign count         = count_q;
  assign full          = full_q;
  assign err_comp      = err_q;

endmodule

// File: tb/tb_hack_encoder.sv
// Bench for hack_encoder: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the encoder.
module tb_hack_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 15;

  // c1..c6 for mnemonics 0..17; M forms reuse their A counterpart with a=1.
  localparam logic [5:0] C_BITS [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
  localparam int M_TO_A [10] = '{4, 6, 8, 10, 12, 13, 14, 15, 16, 17};

  logic            clk;
  logic            reset;
  logic            clear;
  logic [ADDR_W:0] count;
  logic            full;
  logic            err_comp;

  hack_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  hack_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .bus      (bus),
    .count    (count),
    .full     (full),
    .err_comp (err_comp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the pending write, instructions emitted so far, sticky error.
  bit          m_valid;
  int          m_addr;
  logic [15:0] m_instr;
  int          m_count;
  bit          m_err;
  int          wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_encode(input logic is_c, input logic [14:0] v,
                                             input logic [4:0] comp, input logic [2:0] d,
                                             input logic [2:0] j);
    int   k;
    logic a;
    if (!is_c) return {1'b0, v};
    k = int'(comp);
    a = 1'b0;
    if (k >= 18) begin
      a = 1'b1;
      k = M_TO_A[k-18];
    end
    return {3'b111, a, C_BITS[k], d, j};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_addr  = 0;
    m_instr = '0;
    m_count = 0;
    m_err   = 0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("err_comp", 32'(err_comp), 32'(m_err));
    if (m_valid) begin
      chk("out_addr", 32'(bus.out_addr), 32'(m_addr));
      chk("out_instr", 32'(bus.out_instr), 32'(m_instr));
    end
  endtask

  // One clock with the inputs currently driven; predicts and checks the result.
  task automatic cycle();
    bit rdy, acc, bad, taken;
    #1;
    rdy   = !m_valid || bus.out_ready;
    rdy   = rdy && (m_count < DEPTH);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    acc   = rdy && bus.in_valid;
    bad   = acc && bus.in_is_c && (bus.in_comp >= 5'd28);
    taken = m_valid && bus.out_ready;
    if (clear) begin
      m_valid = 0;
      m_count = 0;
      m_err   = 0;
    end else begin
      if (taken) wr_q.push_back(m_addr);
      if (acc && !bad) begin
        m_valid = 1;
        m_addr  = m_count;
        m_instr = ref_encode(bus.in_is_c, bus.in_value, bus.in_comp, bus.in_dest,
                             bus.in_jump);
        m_count++;
      end else if (taken) begin
        m_valid = 0;
      end
      if (bad) m_err = 1;
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic drive(input bit v, input bit is_c, input logic [14:0] val,
                       input logic [4:0] comp, input logic [2:0] d, input logic [2:0] j);
    bus.in_valid = v;
    bus.in_is_c  = is_c;
    bus.in_value = val;
    bus.in_comp  = comp;
    bus.in_dest  = d;
    bus.in_jump  = j;
  endtask

  task automatic do_clear();
    clear        = 1'b1;
    bus.in_valid = 1'b0;
    cycle();
    clear        = 1'b0;
    wr_q.delete();
  endtask

  task automatic chk_writes(input string tag, input int n);
    chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n));
    foreach (wr_q[i]) chk({tag, "_addr"}, 32'(wr_q[i]), 32'(i));
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, '0, '0, '0, '0);
    model_reset();
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_addr", 32'(bus.out_addr), 32'(0));
    chk("rst_out_instr", 32'(bus.out_instr), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_flags", 32'({full, err_comp}), 32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A-instruction, first accept right after reset release.
    bus.out_ready = 1'b1;
    drive(1, 0, 15'h1234, '0, '0, '0);
    cycle();
    chk("a_instr", 32'(bus.out_instr), 32'h1234);
    chk("a_addr", 32'(bus.out_addr), 32'(0));
    bus.in_valid = 1'b0;
    cycle();
    chk("a_count", 32'(count), 32'(1));

    // C-instruction encodings.
    do_clear();
    drive(1, 1, '0, 5'd25, 3'b010, 3'b011);
    cycle();
    chk("c_mminusd", 32'(bus.out_instr), 32'hF1D3);
    drive(1, 1, '0, 5'd0, 3'b000, 3'b111);
    cycle();
    chk("c_zero_jmp", 32'(bus.out_instr), 32'hEA87);
    bus.in_valid = 1'b0;
    cycle();

    // Backpressure then no-bubble streaming.
    do_clear();
    bus.out_ready = 1'b0;
    drive(1, 0, 15'h0011, '0, '0, '0);
    cycle();
    drive(1, 0, 15'h0022, '0, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    chk("stall_instr", 32'(bus.out_instr), 32'h0011);
    bus.out_ready = 1'b1;
    cycle();
    drive(1, 0, 15'h0033, '0, '0, '0);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk_writes("stream", 3);

    // Illegal comp dropped between two legal records.
    do_clear();
    drive(1, 0, 15'h0100, '0, '0, '0);
    cycle();
    drive(1, 1, '0, 5'd29, 3'b001, 3'b001);
    cycle();
    drive(1, 1, '0, 5'd3, 3'b010, 3'b000);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk_writes("badcomp", 2);
    chk("badcomp_err", 32'(err_comp), 32'(1));
    chk("badcomp_count", 32'(count), 32'(2));

    // Fill to DEPTH, then clear.
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 15'(i + 5), '0, '0, '0);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    chk_writes("fill", DEPTH);
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_in_ready", 32'(bus.in_ready), 32'(0));
    do_clear();
    chk("clr_count", 32'(count), 32'(0));
    drive(1, 0, 15'h0777, '0, '0, '0);
    cycle();
    chk("clr_addr", 32'(bus.out_addr), 32'(0));

    // Reset in the middle of a stalled write.
    do_clear();
    bus.out_ready = 1'b0;
    drive(1, 0, 15'h0555, '0, '0, '0);
    cycle();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_count", 32'(count), 32'(0));
    model_reset();
    wr_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1, 0, 15'h0666, '0, '0, '0);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk_writes("post_rst", 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 15'($urandom),
            5'($urandom), 3'($urandom), 3'($urandom));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      clear = (m_count == DEPTH) ? 1'($urandom_range(0, 2) == 0)
                                 : 1'($urandom_range(0, 39) == 0);
      cycle();
      clear = 1'b0;
      if (wr_q.size() > 64) wr_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
